// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Included by fetch_ctrl and its skid FIFO.
package fetch_ctrl_pkg;

  typedef logic [31:0] data_bus_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_BOOT  = 2'd0;
  localparam fetch_state_t ST_RUN   = 2'd1;
  localparam fetch_state_t ST_FLUSH = 2'd2;

  localparam data_bus_t PC_STEP_DEFAULT      = 32'd4;
  localparam data_bus_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    data_bus_t instr;
    data_bus_t pc;
  } fetch_entry_t;

  function automatic data_bus_t align_pc(input data_bus_t addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input data_bus_t addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry fall-through FIFO of fetch entries. An incoming word is visible
// at the head in the same cycle it arrives, so an empty FIFO adds no latency.
module fetch_skid_fifo
  import fetch_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_stored;
  logic w_bypass;
  logic w_do_push;
  logic w_do_pop;

  assign w_stored  = (r_count != 2'd0);
  // Word arriving into an empty FIFO and consumed at once is never stored.
  assign w_bypass  = !w_stored & i_push & i_pop;
  assign w_do_pop  = w_stored & i_pop;
  assign w_do_push = i_push & !w_bypass & ((r_count != 2'd2) | w_do_pop);

  assign o_empty = !w_stored & !i_push;
  assign o_head  = w_stored ? r_mem[r_rd_ptr] : i_push_data;
  assign o_count = r_count;

  // Pointer and occupancy tracking; clear drops everything including a same-cycle push.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= 64'd0;
      r_mem[1] <= 64'd0;
    end else if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one sync-ROM read per cycle
// under a two-slot credit, and hands words to decode with redirect flushing.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter data_bus_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter data_bus_t PC_STEP      = PC_STEP_DEFAULT
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_rom_en,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_data,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  output logic        o_misalign_err
);

  fetch_state_t r_state;
  data_bus_t    r_pc;
  data_bus_t    r_rsp_pc;
  logic         r_inflight;
  logic         r_misalign;

  fetch_state_t w_state_nxt;
  logic         w_issue_state;
  logic         w_rsp_valid;
  logic         w_fifo_empty;
  logic [1:0]   w_fifo_count;
  fetch_entry_t w_rsp_entry;
  fetch_entry_t w_head;
  logic         w_instr_valid;
  logic         w_pop;
  logic [2:0]   w_occupancy;
  logic         w_credit_ok;
  logic         w_issue;

  // A response landing while flushing belongs to the abandoned path.
  assign w_rsp_valid = r_inflight & (r_state != ST_FLUSH);
  assign w_rsp_entry = '{instr: i_rom_data, pc: r_rsp_pc};

  assign w_instr_valid = !i_rst & !w_fifo_empty & !i_redirect_valid;
  assign w_pop         = w_instr_valid & i_instr_ready;

  // Words held plus the one in flight must leave room for the new read.
  assign w_occupancy   = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_credit_ok   = (w_occupancy < (3'd2 + {2'b00, w_pop}));
  assign w_issue_state = (r_state == ST_RUN) | (r_state == ST_FLUSH);
  assign w_issue       = !i_rst & w_issue_state & !i_redirect_valid & w_credit_ok;

  fetch_skid_fifo u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_redirect_valid),
    .i_push      (w_rsp_valid),
    .i_push_data (w_rsp_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Sequencer next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_redirect_valid) w_state_nxt = ST_FLUSH;
        else                  w_state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        if (i_redirect_valid) w_state_nxt = ST_FLUSH;
        else                  w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // PC, FSM, in-flight tracking and the sticky misalignment flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= align_pc(RESET_VECTOR);
      r_rsp_pc   <= align_pc(RESET_VECTOR);
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (i_redirect_valid) begin
        r_pc <= align_pc(i_redirect_target);
      end else if (w_issue) begin
        r_pc <= r_pc + PC_STEP;
      end
      if (w_issue) r_rsp_pc <= r_pc;
      if (i_redirect_valid && is_misaligned(i_redirect_target)) r_misalign <= 1'b1;
    end
  end

  assign o_rom_en       = w_issue;
  assign o_rom_addr     = r_pc;
  assign o_instr_valid  = w_instr_valid;
  assign o_instr        = w_head.instr;
  assign o_instr_pc     = w_head.pc;
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected words are queued as stimulus is
// applied and a negedge monitor compares every accepted instruction.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_entry_t exp_q [$];

  logic        hold_v = 1'b0;
  logic [31:0] hold_pc = 32'd0;
  logic [31:0] hold_instr = 32'd0;

  fetch_ctrl dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_rom_en          (rom_en),
    .o_rom_addr        (rom_addr),
    .i_rom_data        (rom_data),
    .o_instr_valid     (instr_valid),
    .o_instr           (instr),
    .o_instr_pc        (instr_pc),
    .i_instr_ready     (instr_ready),
    .o_misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync ROM model, one cycle latency.
  initial rom_data = 32'd0;
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr ^ 32'hA5A5_0000;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic push_exp(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'hA5A5_0000;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compares accepted words and stability under backpressure.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (hold_v && !rst && !redirect_valid) begin
      check1("hold_valid", instr_valid, 1'b1);
      check("hold_pc", instr_pc, hold_pc);
      check("hold_instr", instr, hold_instr);
    end
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got pc %h expected no transfer", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.instr);
      end
    end
    hold_v     = instr_valid && !instr_ready;
    hold_pc    = instr_pc;
    hold_instr = instr;
  end

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    instr_ready     = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check1("rst_rom_en", rom_en, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_addr", rom_addr, 32'h0000_0000);
    check1("rst_misalign", misalign_err, 1'b0);
    @(posedge clk);
    #1;

    for (int c = 0; c < 37; c++) begin
      rst             = (c == 29);
      redirect_valid  = (c == 16) || (c == 21) || (c == 25) || (c == 29);
      redirect_target = 32'd0;
      instr_ready     = !(((c >= 8) && (c <= 13)) || (c >= 34));
      case (c)
        0: begin
          push_exp(32'h00); push_exp(32'h04); push_exp(32'h08); push_exp(32'h0C);
          push_exp(32'h10); push_exp(32'h14); push_exp(32'h18); push_exp(32'h1C);
        end
        16: begin
          redirect_target = 32'h0000_0040;
          push_exp(32'h40); push_exp(32'h44); push_exp(32'h48);
        end
        21: begin
          redirect_target = 32'h0000_0042;
          push_exp(32'h40); push_exp(32'h44);
        end
        25: begin
          redirect_target = 32'hFFFF_FFFC;
          push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
        end
        29: begin
          redirect_target = 32'h0000_0080;
          push_exp(32'h00); push_exp(32'h04);
        end
        default: ;
      endcase

      @(negedge clk);
      case (c)
        0: begin
          check1("boot_rom_en", rom_en, 1'b0);
          check1("boot_valid", instr_valid, 1'b0);
        end
        1: begin
          check1("first_rom_en", rom_en, 1'b1);
          check("first_addr", rom_addr, 32'h0);
          check1("first_valid", instr_valid, 1'b0);
        end
        2: begin
          check1("first_instr_valid", instr_valid, 1'b1);
          check("first_instr_pc", instr_pc, 32'h0);
        end
        8: begin
          check1("bp_last_issue", rom_en, 1'b1);
          check("bp_last_addr", rom_addr, 32'h1C);
        end
        16: begin
          check1("redir_valid", instr_valid, 1'b0);
          check1("redir_rom_en", rom_en, 1'b0);
        end
        17: begin
          check1("flush_valid", instr_valid, 1'b0);
          check1("flush_rom_en", rom_en, 1'b1);
          check("flush_addr", rom_addr, 32'h40);
          check1("aligned_no_err", misalign_err, 1'b0);
        end
        18: begin
          check1("target_valid", instr_valid, 1'b1);
          check("target_pc", instr_pc, 32'h40);
        end
        22: begin
          check1("misalign_set", misalign_err, 1'b1);
          check("misalign_addr", rom_addr, 32'h40);
        end
        27: check("wrap_pc_hi", instr_pc, 32'hFFFF_FFFC);
        28: check("wrap_pc_lo", instr_pc, 32'h0000_0000);
        29: begin
          check1("rst_redir_rom_en", rom_en, 1'b0);
          check1("rst_redir_valid", instr_valid, 1'b0);
        end
        30: begin
          check1("reboot_rom_en", rom_en, 1'b0);
          check1("reboot_misalign", misalign_err, 1'b0);
        end
        31: begin
          check1("reboot_issue", rom_en, 1'b1);
          check("reboot_addr", rom_addr, 32'h0);
        end
        32: check("reboot_pc", instr_pc, 32'h0);
        36: check("sb_drain", 32'(exp_q.size()), 32'd0);
        default: ;
      endcase
      if ((c >= 3) && (c <= 7)) check1("stream_no_bubble", instr_valid, 1'b1);
      if ((c >= 9) && (c <= 13)) check1("bp_rom_en_low", rom_en, 1'b0);
      if ((c >= 23) && (c <= 28)) check1("misalign_sticky", misalign_err, 1'b1);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
